// File: rtl/clk_rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// clk_rst_seq_pkg
// Shared definitions for the clock-enable / reset sequencer:
//   - seq_state_t : sequencer FSM states
//   - cnt_width() : bit width needed for a counter that must hold max_val
//   - *_MIN/*_MAX : legal parameter ranges, checked at elaboration by the top
// ---------------------------------------------------------------------------
package clk_rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        SEQ       = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int NUM_CH_MIN    = 1;
    localparam int NUM_CH_MAX    = 8;
    localparam int DIV_W_MIN     = 1;
    localparam int LOCK_FILT_MIN = 2;
    localparam int SEQ_GAP_MIN   = 1;

    // Width of a counter that has to reach max_val; never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// ---------------------------------------------------------------------------
// clk_en_div
// One channel's clock-enable divider. While held, the count sits at 0 and no
// enable is produced. Once released, ce pulses for one cycle every N cycles,
// where N is the ratio input with 0 treated as 1 (N=1 gives ce constantly 1).
// The count is compared against the live ratio, so a ratio change applies to
// the count in progress and a lowered ratio wraps on the next edge.
//
// Ports:
//   clock : sole clock
//   reset : synchronous active-high reset
//   hold  : keep the divider cleared (channel domain in reset)
//   ratio : divide ratio N
//   ce    : registered single-cycle clock-enable
// ---------------------------------------------------------------------------
module clk_en_div #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic [DIV_W-1:0] ratio,
    output logic             ce
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] terminal;

    // Terminal count is N-1; a ratio of 0 behaves as 1, so its terminal is 0.
    assign terminal = (ratio == '0) ? '0 : ratio - 1'b1;

    // The >= test (rather than ==) lets a count that is already past a newly
    // lowered terminal wrap immediately instead of running round the full range.
    always_ff @(posedge clock) begin
        if (reset || hold) begin
            count <= '0;
            ce    <= 1'b0;
        end else if (count >= terminal) begin
            count <= '0;
            ce    <= 1'b1;
        end else begin
            count <= count + 1'b1;
            ce    <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// ---------------------------------------------------------------------------
// clk_rst_seq
// Qualifies the PLL lock, then releases the per-channel domain resets one at a
// time SEQ_GAP cycles apart and runs a clock-enable divider for each channel.
// Losing lock after qualification started puts every channel back in reset
// and sets a sticky LOCK_LOST flag.
//
// Ports:
//   CLK0      : sole clock (PLL global clock)
//   RST       : synchronous active-high reset
//   LOCK_IN   : raw PLL lock, asynchronous to CLK0
//   DIV_RATIO : per-channel divide ratios, slice i belongs to channel i
//   CLR_LOST  : clears LOCK_LOST
//   CE        : per-channel clock-enable pulses
//   RST_OUT   : per-channel synchronous active-high domain resets
//   LOCK_OK   : lock qualified and all channels released
//   LOCK_LOST : sticky lock-dropped flag
// ---------------------------------------------------------------------------
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 8,
    parameter int LOCK_FILT = 1024,
    parameter int SEQ_GAP   = 16
) (
    input  logic                    CLK0,
    input  logic                    RST,
    input  logic                    LOCK_IN,
    input  logic [NUM_CH*DIV_W-1:0] DIV_RATIO,
    input  logic                    CLR_LOST,
    output logic [NUM_CH-1:0]       CE,
    output logic [NUM_CH-1:0]       RST_OUT,
    output logic                    LOCK_OK,
    output logic                    LOCK_LOST
);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX || DIV_W < DIV_W_MIN ||
        LOCK_FILT < LOCK_FILT_MIN || SEQ_GAP < SEQ_GAP_MIN) begin : g_param_check
        $error("clk_rst_seq: parameter out of range");
    end

    // The sequence counter counts cycles since SEQ entry; the last channel is
    // released at LAST_REL and the FSM moves to RUN one cycle later.
    localparam int LAST_REL = (NUM_CH - 1) * SEQ_GAP;
    localparam int FILT_W   = cnt_width(LOCK_FILT - 1);
    localparam int SEQ_W    = cnt_width(LAST_REL + 1);

    localparam logic [FILT_W-1:0] FILT_TERM = FILT_W'(LOCK_FILT - 1);
    localparam logic [SEQ_W-1:0]  SEQ_TERM  = SEQ_W'(LAST_REL + 1);

    logic              lock_meta;
    logic              lock_s;
    seq_state_t        state;
    seq_state_t        state_next;
    logic [FILT_W-1:0] filt_cnt;
    logic [FILT_W-1:0] filt_cnt_next;
    logic [SEQ_W-1:0]  seq_cnt;
    logic [SEQ_W-1:0]  seq_cnt_next;
    logic [NUM_CH-1:0] rst_out_q;
    logic [NUM_CH-1:0] rst_out_next;
    logic              lock_ok_q;
    logic              lock_ok_next;
    logic              lock_lost_q;
    logic              lost_set;
    logic [NUM_CH-1:0] ce_q;

    // Two-flop synchroniser for the asynchronous PLL lock; lock_s is the
    // only form of the lock the rest of the design looks at.
    always_ff @(posedge CLK0) begin
        if (RST) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= LOCK_IN;
            lock_s    <= lock_meta;
        end
    end

    // Next-state logic. Everything defaults to the "no lock" picture (all
    // channels in reset, counters cleared), so a lock drop in any state only
    // has to pick WAIT_LOCK and decide whether that counts as a lost lock.
    // Channel 0 is released on the very edge that enters SEQ, which is why
    // the sequence counter starts at 1 there.
    always_comb begin
        state_next    = state;
        filt_cnt_next = '0;
        seq_cnt_next  = '0;
        rst_out_next  = '1;
        lock_ok_next  = 1'b0;
        lost_set      = 1'b0;

        if (!lock_s) begin
            state_next = WAIT_LOCK;
            lost_set   = (state != WAIT_LOCK);
        end else begin
            case (state)
                WAIT_LOCK: begin
                    state_next = FILTER;
                end
                FILTER: begin
                    if (filt_cnt == FILT_TERM) begin
                        state_next      = SEQ;
                        seq_cnt_next    = SEQ_W'(1);
                        rst_out_next[0] = 1'b0;
                    end else begin
                        filt_cnt_next = filt_cnt + 1'b1;
                    end
                end
                SEQ: begin
                    if (seq_cnt == SEQ_TERM) begin
                        state_next   = RUN;
                        rst_out_next = '0;
                        lock_ok_next = 1'b1;
                    end else begin
                        seq_cnt_next = seq_cnt + 1'b1;
                        for (int i = 0; i < NUM_CH; i++) begin
                            rst_out_next[i] = !(int'(seq_cnt) >= i * SEQ_GAP);
                        end
                    end
                end
                RUN: begin
                    rst_out_next = '0;
                    lock_ok_next = 1'b1;
                end
                default: begin
                    state_next = WAIT_LOCK;
                end
            endcase
        end
    end

    // State, counters and registered outputs. A lock drop that coincides
    // with CLR_LOST keeps LOCK_LOST set so the event is never missed.
    always_ff @(posedge CLK0) begin
        if (RST) begin
            state       <= WAIT_LOCK;
            filt_cnt    <= '0;
            seq_cnt     <= '0;
            rst_out_q   <= '1;
            lock_ok_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state     <= state_next;
            filt_cnt  <= filt_cnt_next;
            seq_cnt   <= seq_cnt_next;
            rst_out_q <= rst_out_next;
            lock_ok_q <= lock_ok_next;
            if (lost_set) begin
                lock_lost_q <= 1'b1;
            end else if (CLR_LOST) begin
                lock_lost_q <= 1'b0;
            end
        end
    end

    // Each divider is held while its domain reset is asserted now or is about
    // to be asserted; the second term makes CE drop on the same edge as
    // RST_OUT rises after a lock loss, and the first keeps the first enable a
    // full ratio period after RST_OUT falls.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_en_div #(
            .DIV_W (DIV_W)
        ) u_div (
            .clock (CLK0),
            .reset (RST),
            .hold  (rst_out_q[g] | rst_out_next[g]),
            .ratio (DIV_RATIO[g*DIV_W +: DIV_W]),
            .ce    (ce_q[g])
        );
    end

    assign CE        = ce_q;
    assign RST_OUT   = rst_out_q;
    assign LOCK_OK   = lock_ok_q;
    assign LOCK_LOST = lock_lost_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_clk_rst_seq
// Self-checking bench for clk_rst_seq (NUM_CH=4, LOCK_FILT=8, SEQ_GAP=4).
// A reference model tracks how many consecutive cycles the synchronised lock
// has been high and derives every channel's reset release and LOCK_OK from
// that run length; each channel's enable is modelled as elapsed cycles since
// release or since its last pulse. Directed scenarios are followed by a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_clk_rst_seq;

    localparam int NUM_CH    = 4;
    localparam int DIV_W     = 8;
    localparam int LOCK_FILT = 8;
    localparam int SEQ_GAP   = 4;
    localparam int FIRST_REL = LOCK_FILT + 1;
    localparam int RUN_AT    = LOCK_FILT + 2 + (NUM_CH - 1) * SEQ_GAP;

    logic                    clock;
    logic                    rst;
    logic                    lock_in;
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic                    clr_lost;
    logic [NUM_CH-1:0]       ce;
    logic [NUM_CH-1:0]       rst_out;
    logic                    lock_ok;
    logic                    lock_lost;

    int check_count = 0;
    int fail_count  = 0;

    logic [31:0]       cur_ratio;
    bit                m_sync1   = 1'b0;
    bit                m_sync2   = 1'b0;
    int                m_good    = 0;
    logic              m_lost    = 1'b0;
    logic              m_ok      = 1'b0;
    logic [NUM_CH-1:0] m_rst_out = '1;
    logic [NUM_CH-1:0] m_ce      = '0;
    int                m_elapsed [NUM_CH];

    clk_rst_seq #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .LOCK_FILT (LOCK_FILT),
        .SEQ_GAP   (SEQ_GAP)
    ) dut (
        .CLK0      (clock),
        .RST       (rst),
        .LOCK_IN   (lock_in),
        .DIV_RATIO (div_ratio),
        .CLR_LOST  (clr_lost),
        .CE        (ce),
        .RST_OUT   (rst_out),
        .LOCK_OK   (lock_ok),
        .LOCK_LOST (lock_lost)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model, evaluated on every rising edge from the inputs seen
    // at that edge. m_good is the number of consecutive edges at which the
    // synchronised lock was high: lock qualification starts at m_good=1,
    // channel i is released at m_good = LOCK_FILT+1+i*SEQ_GAP and LOCK_OK
    // follows one cycle after the last release.
    always @(posedge clock) begin : ref_model
        logic [NUM_CH-1:0] prev_rst;
        int                n;
        if (rst) begin
            m_sync1   = 1'b0;
            m_sync2   = 1'b0;
            m_good    = 0;
            m_lost    = 1'b0;
            m_ok      = 1'b0;
            m_rst_out = '1;
            m_ce      = '0;
            for (int i = 0; i < NUM_CH; i++) m_elapsed[i] = 0;
        end else begin
            prev_rst = m_rst_out;
            if (!m_sync2 && m_good > 0) m_lost = 1'b1;
            else if (clr_lost)          m_lost = 1'b0;
            m_good = m_sync2 ? m_good + 1 : 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_rst_out[i] = (m_good < FIRST_REL + i * SEQ_GAP);
            end
            m_ok = (m_good >= RUN_AT);
            for (int i = 0; i < NUM_CH; i++) begin
                n = int'(div_ratio[i*DIV_W +: DIV_W]);
                if (n == 0) n = 1;
                if (prev_rst[i] || m_rst_out[i]) begin
                    m_elapsed[i] = 0;
                    m_ce[i]      = 1'b0;
                end else begin
                    m_elapsed[i] = m_elapsed[i] + 1;
                    if (m_elapsed[i] >= n) begin
                        m_ce[i]      = 1'b1;
                        m_elapsed[i] = 0;
                    end else begin
                        m_ce[i] = 1'b0;
                    end
                end
            end
            m_sync2 = m_sync1;
            m_sync1 = lock_in;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, then compares every
    // output with the model just after the following rising edge.
    task automatic applyStimulus(input logic r, input logic lk, input logic clr,
                                 input logic [31:0] ratio);
        @(negedge clock);
        rst       = r;
        lock_in   = lk;
        clr_lost  = clr;
        div_ratio = ratio;
        @(posedge clock);
        #1;
        checkOutput("model_rst_out",   32'(rst_out),   32'(m_rst_out));
        checkOutput("model_ce",        32'(ce),        32'(m_ce));
        checkOutput("model_lock_ok",   32'(lock_ok),   32'(m_ok));
        checkOutput("model_lock_lost", 32'(lock_lost), 32'(m_lost));
    endtask

    // Runs a clean lock-up with LOCK_IN high before edge 1 and checks the
    // release edges 11/15/19/23 and LOCK_OK at edge 24.
    task automatic checkSequence(input string tag);
        for (int e = 1; e <= 25; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, cur_ratio);
            case (e)
                10: checkOutput({tag, "_e10_rst"}, 32'(rst_out), 32'hF);
                11: checkOutput({tag, "_e11_rst"}, 32'(rst_out), 32'hE);
                15: checkOutput({tag, "_e15_rst"}, 32'(rst_out), 32'hC);
                19: checkOutput({tag, "_e19_rst"}, 32'(rst_out), 32'h8);
                23: begin
                    checkOutput({tag, "_e23_rst"}, 32'(rst_out), 32'h0);
                    checkOutput({tag, "_e23_ok"},  32'(lock_ok), 32'h0);
                end
                24: checkOutput({tag, "_e24_ok"},  32'(lock_ok), 32'h1);
                default: ;
            endcase
        end
    endtask

    initial begin : stimulus
        int ce_tally [NUM_CH];
        int reached;
        int drop_left;
        int ch;
        logic r, lk, clr;

        rst       = 1'b1;
        lock_in   = 1'b0;
        clr_lost  = 1'b0;
        cur_ratio = {8'd255, 8'd1, 8'd0, 8'd3};
        div_ratio = cur_ratio;

        // Reset state.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, cur_ratio);
        checkOutput("reset_rst_out", 32'(rst_out),   32'hF);
        checkOutput("reset_ce",      32'(ce),        32'h0);
        checkOutput("reset_lock_ok", 32'(lock_ok),   32'h0);
        checkOutput("reset_lost",    32'(lock_lost), 32'h0);

        // Nominal lock-up.
        $display("[TB] clean lock-up sequence");
        checkSequence("seq1");

        // One-cycle lock_s drop at filter count 5, with CLR_LOST on the same edge.
        $display("[TB] lock glitch during filtering");
        applyStimulus(1'b1, 1'b0, 1'b0, cur_ratio);
        for (int e = 1; e <= 32; e++) begin
            lk  = (e != 7);
            clr = (e == 9);
            applyStimulus(1'b0, lk, clr, cur_ratio);
            if (e == 8)  checkOutput("glitch_lost_before", 32'(lock_lost), 32'h0);
            if (e == 9)  checkOutput("glitch_lost_set",    32'(lock_lost), 32'h1);
            if (e == 17) checkOutput("glitch_e17_rst",     32'(rst_out),   32'hF);
            if (e == 18) checkOutput("glitch_e18_rst",     32'(rst_out),   32'hE);
            if (e == 31) checkOutput("glitch_e31_ok",      32'(lock_ok),   32'h1);
        end

        // Mixed ratios in RUN: 3, 0, 1, 255.
        $display("[TB] ratio mix in RUN");
        for (int i = 0; i < NUM_CH; i++) ce_tally[i] = 0;
        for (int c = 0; c < 765; c++) begin
            applyStimulus(1'b0, 1'b1, (c == 10), cur_ratio);
            if (c == 10) checkOutput("clr_lost", 32'(lock_lost), 32'h0);
            for (int i = 0; i < NUM_CH; i++) ce_tally[i] += int'(ce[i]);
        end
        checkOutput("ce0_count_r3",   32'(ce_tally[0]), 32'd255);
        checkOutput("ce1_count_r0",   32'(ce_tally[1]), 32'd765);
        checkOutput("ce2_count_r1",   32'(ce_tally[2]), 32'd765);
        checkOutput("ce3_count_r255", 32'(ce_tally[3]), 32'd3);

        // Ratio lowered 200 -> 4 while channel 0 is 100 cycles into its count.
        $display("[TB] ratio lowered mid-count");
        cur_ratio[7:0] = 8'd200;
        reached = 0;
        for (int c = 0; c < 500 && reached == 0; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, cur_ratio);
            if (m_elapsed[0] == 100) reached = 1;
        end
        checkOutput("count100_reached", 32'(reached), 32'd1);
        cur_ratio[7:0] = 8'd4;
        applyStimulus(1'b0, 1'b1, 1'b0, cur_ratio);
        checkOutput("wrap_ce0", 32'(ce[0]), 32'd1);
        for (int j = 1; j <= 12; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, cur_ratio);
            checkOutput("after_wrap_ce0", 32'(ce[0]), 32'((j % 4) == 0));
        end

        // Lock lost in RUN, then cleared while lock is still low.
        $display("[TB] lock lost in RUN");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, cur_ratio);
            if (k < 2) checkOutput("drop_ok_hold", 32'(lock_ok), 32'h1);
        end
        checkOutput("drop_rst_out", 32'(rst_out),   32'hF);
        checkOutput("drop_ce",      32'(ce),        32'h0);
        checkOutput("drop_ok",      32'(lock_ok),   32'h0);
        checkOutput("drop_lost",    32'(lock_lost), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, cur_ratio);
        checkOutput("drop_clr_lost", 32'(lock_lost), 32'h0);

        // RST in the middle of SEQ, then a full sequence after release.
        $display("[TB] reset during sequencing");
        for (int e = 1; e <= 14; e++) applyStimulus(1'b0, 1'b1, 1'b0, cur_ratio);
        checkOutput("midseq_rst_out", 32'(rst_out), 32'hE);
        applyStimulus(1'b1, 1'b1, 1'b0, cur_ratio);
        checkOutput("midseq_reset_rst", 32'(rst_out),   32'hF);
        checkOutput("midseq_reset_ce",  32'(ce),        32'h0);
        checkOutput("midseq_reset_ok",  32'(lock_ok),   32'h0);
        checkOutput("midseq_reset_lost", 32'(lock_lost), 32'h0);
        checkSequence("seq2");

        // Randomized traffic: lock glitches, clears, ratio changes, resets.
        $display("[TB] randomized phase");
        drop_left = 0;
        for (int c = 0; c < 1500; c++) begin
            r = ($urandom_range(0, 299) == 0);
            if (drop_left > 0) drop_left--;
            else if ($urandom_range(0, 149) == 0) drop_left = $urandom_range(1, 4);
            lk  = (drop_left == 0);
            clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 39) == 0) begin
                ch = $urandom_range(0, NUM_CH - 1);
                cur_ratio[ch*DIV_W +: DIV_W] = 8'($urandom_range(0, 12));
            end
            applyStimulus(r, lk, clr, cur_ratio);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/clk_rst_seq.md
CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 The block SHALL take these parameters:
- NUM_CH, default 4: number of clock-enable/reset channels, 1..8.
- DIV_W, default 8: divide-ratio width per channel.
- LOCK_FILT, default 1024: consecutive synchronised-lock cycles required before sequencing, ≥2.
- SEQ_GAP, default 16: cycles between successive channel reset releases, ≥1.

REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.

REQ-003 The ports SHALL be, as name, direction, width, meaning:
- CLK0, in, 1: sole clock (PLL global clock).
- RST, in, 1: synchronous active-high reset.
- LOCK_IN, in, 1: raw PLL LOCK, asynchronous to CLK0.
- DIV_RATIO, in, NUM_CH*DIV_W: per-channel divide ratio; slice i belongs to channel i.
- CLR_LOST, in, 1: clears LOCK_LOST.
- CE, out, NUM_CH: per-channel single-cycle clock-enable pulses.
- RST_OUT, out, NUM_CH: per-channel synchronous active-high domain reset.
- LOCK_OK, out, 1: lock qualified and all channels released.
- LOCK_LOST, out, 1: sticky flag, lock dropped after qualification began.

Function
REQ-004 LOCK_IN SHALL pass through a 2-flop synchroniser; lock_s is its output, valid after the 2nd edge.
REQ-005 The FSM SHALL have states WAIT_LOCK, FILTER, SEQ and RUN.
REQ-006 WAIT_LOCK SHALL go to FILTER on the edge after lock_s=1, with the filter counter cleared.
REQ-007 FILTER SHALL spend exactly LOCK_FILT cycles with lock_s=1, then enter SEQ.
REQ-008 In SEQ, RST_OUT[i] SHALL deassert i*SEQ_GAP cycles after SEQ entry.
REQ-009 The FSM SHALL enter RUN one cycle after RST_OUT[NUM_CH-1] deasserts; LOCK_OK=1 only in RUN.
REQ-010 Net timing: with LOCK_IN rising before edge 1, RST_OUT[0] SHALL fall at edge LOCK_FILT+3.
REQ-011 lock_s=0 in any state SHALL give WAIT_LOCK on the next edge:
- all RST_OUT=1, all CE=0, LOCK_OK=0;
- counters cleared;
- LOCK_LOST set if the state was FILTER, SEQ or RUN.
REQ-012 LOCK_LOST SHALL stay set until CLR_LOST=1 or RST; a simultaneous set and clear SHALL leave it set.
REQ-013 While RST_OUT[i]=1, the channel i divide counter SHALL hold 0 and CE[i] SHALL be 0.
REQ-014 Channel i effective ratio N SHALL be DIV_RATIO slice i, with 0 treated as 1.
REQ-015 With N≥2, CE[i] SHALL pulse for one cycle every N cycles; the first pulse comes N cycles after RST_OUT[i] falls.
REQ-016 With N=1, CE[i] SHALL be 1 every cycle from the cycle after RST_OUT[i] falls.
REQ-017 The divide counter SHALL wrap to 0 whenever it is ≥ N-1, so a ratio lowered mid-count never overruns.
REQ-018 A ratio change SHALL take effect on the current count.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 RST=1 SHALL force:
- state WAIT_LOCK;
- synchroniser flops, counters and LOCK_LOST to 0;
- RST_OUT all 1, CE 0, LOCK_OK 0.
REQ-021 RST=1 in RUN SHALL NOT set LOCK_LOST.
REQ-022 Sequencing SHALL restart from WAIT_LOCK after RST deasserts.

Structure
REQ-023 A shared package clk_rst_seq_pkg SHALL hold:
- the FSM state enum;
- a function clog2-sizing the filter and sequence counters;
- the parameter range-check constants.
REQ-024 A sub-module clk_en_div SHALL implement one channel's divide counter and CE; it SHALL be instantiated NUM_CH times by generate.

Verification
REQ-025 The bench SHALL use NUM_CH=4, LOCK_FILT=8, SEQ_GAP=4 and cover:
- LOCK_IN rises before edge 1 -> RST_OUT[0..3] fall at edges 11/15/19/23, LOCK_OK rises at edge 24.
- lock_s drops for 1 cycle at filter count 5 -> back to WAIT_LOCK, LOCK_LOST=1, full 8-cycle filter repeated before SEQ.
- RUN with DIV_RATIO ch0=3, ch1=0, ch2=1, ch3=255 -> CE0 every 3rd cycle; CE1 and CE2 constantly 1; CE3 every 255th cycle.
- ch0 ratio changes 200→4 while the counter is at 100 -> wrap on the next edge, then a pulse every 4 cycles.
- LOCK_IN drops in RUN -> next-but-two edge: all RST_OUT=1, CE=0, LOCK_OK=0, LOCK_LOST=1; CLR_LOST with LOCK_IN still low -> LOCK_LOST=0.
- RST mid-SEQ -> all outputs at reset values next edge, LOCK_LOST unchanged at 0, full sequence after RST release.
